// File: rtl/rv_pkg.sv
// Shared rv32i pipeline definitions: architectural constants and fetch-stage enums.
package rv_pkg;

  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_8000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } fetch_state_t;

  typedef enum logic [1:0] {
    F_OK       = 2'b00,
    F_MISALIGN = 2'b01,
    F_TIMEOUT  = 2'b10
  } fetch_fault_t;

endpackage

// File: rtl/fetch_pending.sv
// Single-entry buffer for a token/PC that arrives while fetch cannot take it directly.
import rv_pkg::*;

module fetch_pending (
  input  logic        clk,
  input  logic        rst,
  input  logic        tok_in,
  input  logic [31:0] pc_in,
  input  logic        idle,
  output logic        valid,
  output logic [31:0] pc,
  output logic        overrun
);

  logic drain;
  logic direct;
  logic store;

  // In IDLE with an empty buffer the FSM consumes the incoming token itself.
  assign drain  = idle && valid;
  assign direct = idle && !valid;
  assign store  = tok_in && !direct;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= 1'b0;
      pc      <= '0;
      overrun <= 1'b0;
    end else if (store) begin
      if (valid && !drain) begin
        overrun <= 1'b1;
      end else begin
        valid <= 1'b1;
        pc    <= pc_in;
      end
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: takes a PC token, reads one word over req/ack and hands
// instruction, PC and fault status to decode with a one-cycle token.
import rv_pkg::*;

module fetch #(
  parameter logic [31:0] RESET_PC = RV_RESET_PC,
  parameter int          TIMEOUT  = 16,
  parameter int          TMO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_pipeline_ctl_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [1:0]  fault,
  output logic        overrun,
  output logic        fetch_pipeline_ctl_out
);

  fetch_state_t state, state_nxt;
  fetch_fault_t fault_q, fault_nxt;
  logic [31:0]  cur_pc, cur_pc_nxt;
  logic [31:0]  addr_q, addr_nxt;
  logic [31:0]  instr_nxt;
  logic [31:0]  pc_out_nxt;
  logic [TMO_W-1:0] cnt, cnt_nxt;

  logic        pend_valid;
  logic [31:0] pend_pc;
  logic        take;
  logic [31:0] sel_pc;

  fetch_pending u_pending (
    .clk     (clk),
    .rst     (rst),
    .tok_in  (fetch_pipeline_ctl_in),
    .pc_in   (pc),
    .idle    (state == IDLE),
    .valid   (pend_valid),
    .pc      (pend_pc),
    .overrun (overrun)
  );

  // A buffered token is older than the live one, so it is served first.
  assign take   = pend_valid || fetch_pipeline_ctl_in;
  assign sel_pc = pend_valid ? pend_pc : pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      fault_q <= F_OK;
      cur_pc  <= '0;
      addr_q  <= '0;
      instr   <= RV_NOP;
      pc_out  <= RESET_PC;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      fault_q <= fault_nxt;
      cur_pc  <= cur_pc_nxt;
      addr_q  <= addr_nxt;
      instr   <= instr_nxt;
      pc_out  <= pc_out_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    fault_nxt  = fault_q;
    cur_pc_nxt = cur_pc;
    addr_nxt   = addr_q;
    instr_nxt  = instr;
    pc_out_nxt = pc_out;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        if (take) begin
          cur_pc_nxt = sel_pc;
          cnt_nxt    = '0;
          if (sel_pc[1:0] == 2'b00) begin
            state_nxt = WAIT;
            addr_nxt  = sel_pc;
          end else begin
            state_nxt  = DONE;
            instr_nxt  = RV_NOP;
            fault_nxt  = F_MISALIGN;
            pc_out_nxt = sel_pc;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt + TMO_W'(1);
        // An ack in the final allowed cycle still counts as success.
        if (imem_ack) begin
          state_nxt  = DONE;
          instr_nxt  = imem_rdata;
          fault_nxt  = F_OK;
          pc_out_nxt = cur_pc;
        end else if (cnt_nxt == TMO_W'(TIMEOUT)) begin
          state_nxt  = DONE;
          instr_nxt  = RV_NOP;
          fault_nxt  = F_TIMEOUT;
          pc_out_nxt = cur_pc;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign imem_req               = (state == WAIT);
  assign imem_addr              = addr_q;
  assign fault                  = fault_q;
  assign fetch_pipeline_ctl_out = (state == DONE);

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage: reset, normal fetch, misalignment, timeout,
// token buffering/overrun and reset in the middle of a memory request.
module tb_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_pipeline_ctl_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [1:0]  fault;
  logic        overrun;
  logic        fetch_pipeline_ctl_out;

  int vectors = 0;
  int miscompares = 0;

  localparam int TIMEOUT = 16;

  fetch #(.TIMEOUT(TIMEOUT)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .pc                     (pc),
    .fetch_pipeline_ctl_in  (fetch_pipeline_ctl_in),
    .imem_req               (imem_req),
    .imem_addr              (imem_addr),
    .imem_ack               (imem_ack),
    .imem_rdata             (imem_rdata),
    .instr                  (instr),
    .pc_out                 (pc_out),
    .fault                  (fault),
    .overrun                (overrun),
    .fetch_pipeline_ctl_out (fetch_pipeline_ctl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic tok, input logic [31:0] pc_val, input logic ack, input logic [31:0] rdata);
    fetch_pipeline_ctl_in = tok;
    pc                    = pc_val;
    imem_ack              = ack;
    imem_rdata            = rdata;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);

    // Reset state
    repeat (3) tick();
    check_output("rst_pc_out", pc_out, 32'h0000_8000);
    check_output("rst_instr", instr, 32'h0000_0013);
    check_output("rst_req", {31'b0, imem_req}, 32'h0);
    check_output("rst_addr", imem_addr, 32'h0);
    check_output("rst_ctl", {31'b0, fetch_pipeline_ctl_out}, 32'h0);
    check_output("rst_fault", {30'b0, fault}, 32'h0);
    check_output("rst_ovr", {31'b0, overrun}, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("idle_req", {31'b0, imem_req}, 32'h0);
      check_output("idle_ctl", {31'b0, fetch_pipeline_ctl_out}, 32'h0);
    end

    // Basic aligned fetch, ack in first WAIT cycle
    apply_stimulus(1'b1, 32'h0000_8000, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b1, 32'h0050_0093);
    check_output("basic_req", {31'b0, imem_req}, 32'h1);
    check_output("basic_addr", imem_addr, 32'h0000_8000);
    check_output("basic_ctl_early", {31'b0, fetch_pipeline_ctl_out}, 32'h0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    check_output("basic_ctl", {31'b0, fetch_pipeline_ctl_out}, 32'h1);
    check_output("basic_instr", instr, 32'h0050_0093);
    check_output("basic_pc_out", pc_out, 32'h0000_8000);
    check_output("basic_fault", {30'b0, fault}, 32'h0);
    check_output("basic_req_drop", {31'b0, imem_req}, 32'h0);
    tick();
    check_output("basic_ctl_off", {31'b0, fetch_pipeline_ctl_out}, 32'h0);
    check_output("basic_instr_hold", instr, 32'h0050_0093);

    // Misaligned PC: no request, immediate token out
    apply_stimulus(1'b1, 32'h0000_8002, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    check_output("mis_ctl", {31'b0, fetch_pipeline_ctl_out}, 32'h1);
    check_output("mis_req", {31'b0, imem_req}, 32'h0);
    check_output("mis_instr", instr, 32'h0000_0013);
    check_output("mis_fault", {30'b0, fault}, 32'h1);
    check_output("mis_pc_out", pc_out, 32'h0000_8002);
    tick();
    check_output("mis_ctl_off", {31'b0, fetch_pipeline_ctl_out}, 32'h0);

    // Timeout: request held exactly TIMEOUT cycles
    apply_stimulus(1'b1, 32'h0000_8004, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      tick();
    end
    check_output("tmo_req_cycles", n, TIMEOUT);
    check_output("tmo_ctl", {31'b0, fetch_pipeline_ctl_out}, 32'h1);
    check_output("tmo_fault", {30'b0, fault}, 32'h2);
    check_output("tmo_instr", instr, 32'h0000_0013);
    check_output("tmo_pc_out", pc_out, 32'h0000_8004);
    tick();

    // Ack in the last allowed cycle wins over timeout
    apply_stimulus(1'b1, 32'h0000_8018, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (TIMEOUT - 1) tick();
    check_output("late_req", {31'b0, imem_req}, 32'h1);
    check_output("late_ctl", {31'b0, fetch_pipeline_ctl_out}, 32'h0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 32'h1234_5678);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    check_output("late_ctl_on", {31'b0, fetch_pipeline_ctl_out}, 32'h1);
    check_output("late_fault", {30'b0, fault}, 32'h0);
    check_output("late_instr", instr, 32'h1234_5678);
    tick();

    // Buffering: second token arrives during the first fetch
    apply_stimulus(1'b1, 32'h0000_8008, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b1, 32'h0000_800C, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b1, 32'h0000_00A1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    check_output("buf1_ctl", {31'b0, fetch_pipeline_ctl_out}, 32'h1);
    check_output("buf1_pc_out", pc_out, 32'h0000_8008);
    check_output("buf1_instr", instr, 32'h0000_00A1);
    tick();
    check_output("buf_idle_ctl", {31'b0, fetch_pipeline_ctl_out}, 32'h0);
    tick();
    check_output("buf2_req", {31'b0, imem_req}, 32'h1);
    check_output("buf2_addr", imem_addr, 32'h0000_800C);
    tick();
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b1, 32'h0000_00B2);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    check_output("buf2_ctl", {31'b0, fetch_pipeline_ctl_out}, 32'h1);
    check_output("buf2_pc_out", pc_out, 32'h0000_800C);
    check_output("buf2_instr", instr, 32'h0000_00B2);
    check_output("buf_no_ovr", {31'b0, overrun}, 32'h0);
    tick();

    // Overrun: third token while buffer is full is dropped
    apply_stimulus(1'b1, 32'h0000_8020, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b1, 32'h0000_8024, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b1, 32'h0000_8028, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b1, 32'h0000_00C3);
    check_output("ovr_set", {31'b0, overrun}, 32'h1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    check_output("ovr_pc1", pc_out, 32'h0000_8020);
    tick();
    tick();
    check_output("ovr_addr2", imem_addr, 32'h0000_8024);
    apply_stimulus(1'b0, 32'h0, 1'b1, 32'h0000_00D4);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    check_output("ovr_pc2", pc_out, 32'h0000_8024);
    tick();
    tick();
    check_output("ovr_dropped_req", {31'b0, imem_req}, 32'h0);
    check_output("ovr_dropped_ctl", {31'b0, fetch_pipeline_ctl_out}, 32'h0);
    check_output("ovr_sticky", {31'b0, overrun}, 32'h1);

    // Reset in the middle of a request
    apply_stimulus(1'b1, 32'h0000_8030, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    check_output("mid_req_before", {31'b0, imem_req}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_output("mid_req_drop", {31'b0, imem_req}, 32'h0);
    check_output("mid_ovr_clr", {31'b0, overrun}, 32'h0);
    check_output("mid_pc_out", pc_out, 32'h0000_8000);
    tick();
    rst = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
    check_output("mid_late_ctl", {31'b0, fetch_pipeline_ctl_out}, 32'h0);
    tick();
    check_output("mid_late_ctl2", {31'b0, fetch_pipeline_ctl_out}, 32'h0);
    check_output("mid_late_instr", instr, 32'h0000_0013);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
